score_keeper: RTL and testbench

- Accumulates the Tetris score as four BCD digits: thousands, hundreds, tens, units.
- Sits upstream of the playfield/score renderer. Its digit outputs replace the constant digit codes currently driven into the four segment7 decoders.
- Consumes one line-clear event per settled piece from the settling/line-clear logic.
- Adds the points for each event digit-serially through a small FSM and publishes the committed score atomically.

---
 rtl/score_keeper.sv | 186 ++++++++++++++++++
 tb/tb_score_keeper.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Four-digit BCD Tetris score accumulator; adds per-event points digit-serially and commits atomically.
// Optional level/velocity tracking is enabled with `define SCORE_KEEPER_LEVEL_EN.
module score_keeper #(
  parameter logic [3:0] PTS_1           = 4'd1,
  parameter logic [3:0] PTS_2           = 4'd3,
  parameter logic [3:0] PTS_3           = 4'd5,
  parameter logic [3:0] PTS_4           = 4'd8,
  parameter int         LINES_PER_LEVEL = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       lines_valid,
  input  logic [2:0] lines_cleared,
  output logic       busy,
  output logic       score_update,
  output logic [3:0] thsnd_digit,
  output logic [3:0] hndrd_digit,
  output logic [3:0] tens_digit,
  output logic [3:0] units_digit,
`ifdef SCORE_KEEPER_LEVEL_EN
  output logic [3:0] level,
  output logic [1:0] velocity,
`endif
  output logic       saturated
);

  typedef enum logic [2:0] {IDLE, ADD_U, ADD_T, ADD_H, ADD_K, COMMIT} state_t;

  state_t     state_q, state_d;
  logic [3:0] dk_q, dh_q, dt_q, du_q, dk_d, dh_d, dt_d, du_d;
  logic [3:0] wk_q, wh_q, wt_q, wu_q, wk_d, wh_d, wt_d, wu_d;
  logic [3:0] addend_q, addend_d;
  logic       carry_q, carry_d;
  logic       sat_q, sat_d;
  logic       upd_q, upd_d;
  logic       accept;
  logic [4:0] dsum;

  // Returns {carry_out, bcd_digit} of digit + addend + carry_in.
  function automatic logic [4:0] bcd_add(input logic [3:0] d, input logic [3:0] a, input logic c);
    logic [4:0] s;
    s = {1'b0, d} + {1'b0, a} + {4'd0, c};
    if (s > 5'd9) begin
      s = s - 5'd10;
      return {1'b1, s[3:0]};
    end
    return {1'b0, s[3:0]};
  endfunction

  assign accept = lines_valid && (lines_cleared inside {[3'd1:3'd4]}) && !clear;

  always_comb begin
    state_d  = state_q;
    dk_d = dk_q; dh_d = dh_q; dt_d = dt_q; du_d = du_q;
    wk_d = wk_q; wh_d = wh_q; wt_d = wt_q; wu_d = wu_q;
    addend_d = addend_q;
    carry_d  = carry_q;
    sat_d    = sat_q;
    upd_d    = 1'b0;
    dsum     = 5'd0;
    if (clear) begin
      state_d = IDLE;
      dk_d = 4'd0; dh_d = 4'd0; dt_d = 4'd0; du_d = 4'd0;
      wk_d = 4'd0; wh_d = 4'd0; wt_d = 4'd0; wu_d = 4'd0;
      carry_d = 1'b0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          case (lines_cleared)
            3'd1:    addend_d = PTS_1;
            3'd2:    addend_d = PTS_2;
            3'd3:    addend_d = PTS_3;
            default: addend_d = PTS_4;
          endcase
          wk_d = dk_q; wh_d = dh_q; wt_d = dt_q; wu_d = du_q;
          carry_d = 1'b0;
          state_d = ADD_U;
        end
        ADD_U: begin
          dsum = bcd_add(wu_q, addend_q, 1'b0);
          wu_d = dsum[3:0]; carry_d = dsum[4]; state_d = ADD_T;
        end
        ADD_T: begin
          dsum = bcd_add(wt_q, 4'd0, carry_q);
          wt_d = dsum[3:0]; carry_d = dsum[4]; state_d = ADD_H;
        end
        ADD_H: begin
          dsum = bcd_add(wh_q, 4'd0, carry_q);
          wh_d = dsum[3:0]; carry_d = dsum[4]; state_d = ADD_K;
        end
        ADD_K: begin
          // An overflow out of the thousands clamps the whole score at 9999.
          dsum = {1'b0, wk_q} + {4'd0, carry_q};
          if (dsum > 5'd9) begin
            wk_d = 4'd9; wh_d = 4'd9; wt_d = 4'd9; wu_d = 4'd9;
            sat_d = 1'b1;
          end else begin
            wk_d = dsum[3:0];
          end
          carry_d = 1'b0;
          state_d = COMMIT;
        end
        COMMIT: begin
          dk_d = wk_q; dh_d = wh_q; dt_d = wt_q; du_d = wu_q;
          upd_d   = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      dk_q <= 4'd0; dh_q <= 4'd0; dt_q <= 4'd0; du_q <= 4'd0;
      wk_q <= 4'd0; wh_q <= 4'd0; wt_q <= 4'd0; wu_q <= 4'd0;
      addend_q <= 4'd0;
      carry_q  <= 1'b0;
      sat_q    <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dk_q <= dk_d; dh_q <= dh_d; dt_q <= dt_d; du_q <= du_d;
      wk_q <= wk_d; wh_q <= wh_d; wt_q <= wt_d; wu_q <= wu_d;
      addend_q <= addend_d;
      carry_q  <= carry_d;
      sat_q    <= sat_d;
      upd_q    <= upd_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign score_update = upd_q;
  assign saturated    = sat_q;
  assign thsnd_digit  = dk_q;
  assign hndrd_digit  = dh_q;
  assign tens_digit   = dt_q;
  assign units_digit  = du_q;

`ifdef SCORE_KEEPER_LEVEL_EN
  logic [7:0] lines_cnt_q, lines_cnt_d, lvl_sum;
  logic [2:0] lines_add_q, lines_add_d;
  logic [3:0] level_q, level_d;

  // Lines from the accepted event are folded into the counter when the score commits.
  always_comb begin
    lines_cnt_d = lines_cnt_q;
    lines_add_d = lines_add_q;
    level_d     = level_q;
    lvl_sum     = lines_cnt_q + {5'd0, lines_add_q};
    if (clear) begin
      lines_cnt_d = 8'd0;
      lines_add_d = 3'd0;
      level_d     = 4'd0;
    end else if (state_q == IDLE && accept) begin
      lines_add_d = lines_cleared;
    end else if (state_q == COMMIT) begin
      if (lvl_sum >= 8'(LINES_PER_LEVEL)) begin
        lines_cnt_d = lvl_sum - 8'(LINES_PER_LEVEL);
        level_d     = (level_q == 4'd9) ? 4'd9 : level_q + 4'd1;
      end else begin
        lines_cnt_d = lvl_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lines_cnt_q <= 8'd0;
      lines_add_q <= 3'd0;
      level_q     <= 4'd0;
    end else begin
      lines_cnt_q <= lines_cnt_d;
      lines_add_q <= lines_add_d;
      level_q     <= level_d;
    end
  end

  assign level    = level_q;
  assign velocity = level_q[3:2];
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: latency, BCD carry, saturation, ignored/dropped events, clear and reset.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       clear = 1'b0;
  logic       lines_valid = 1'b0;
  logic [2:0] lines_cleared = 3'd0;
  logic       busy, score_update, saturated;
  logic [3:0] thsnd_digit, hndrd_digit, tens_digit, units_digit;
  logic [15:0] dig;
`ifdef SCORE_KEEPER_LEVEL_EN
  logic [3:0] level;
  logic [1:0] velocity;
`endif

  int n_vec = 0;
  int n_fail = 0;

  score_keeper dut (
    .clk(clk), .resetn(resetn), .clear(clear),
    .lines_valid(lines_valid), .lines_cleared(lines_cleared),
    .busy(busy), .score_update(score_update),
    .thsnd_digit(thsnd_digit), .hndrd_digit(hndrd_digit),
    .tens_digit(tens_digit), .units_digit(units_digit),
`ifdef SCORE_KEEPER_LEVEL_EN
    .level(level), .velocity(velocity),
`endif
    .saturated(saturated)
  );

  always #5 clk = ~clk;
  assign dig = {thsnd_digit, hndrd_digit, tens_digit, units_digit};

  // Issues one event at a negedge and returns at the negedge just after the commit edge.
  task automatic do_event(input logic [2:0] n);
    lines_valid = 1'b1; lines_cleared = n;
    @(negedge clk);
    lines_valid = 1'b0; lines_cleared = 3'd0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    #3 resetn = 1'b0;
    #1;
    n_vec++;
    if (dig !== 16'h0000 || busy !== 1'b0 || score_update !== 1'b0 || saturated !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: digits=%h busy=%b upd=%b sat=%b, want 0000/0/0/0", dig, busy, score_update, saturated);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    lines_valid = 1'b1; lines_cleared = 3'd1;
    @(negedge clk);
    lines_valid = 1'b0; lines_cleared = 3'd0;
    for (int i = 1; i <= 5; i++) begin
      n_vec++;
      if (busy !== 1'b1 || score_update !== 1'b0 || dig !== 16'h0000) begin
        n_fail++;
        $display("FAIL single_cycle%0d: busy=%b upd=%b digits=%h, want 1/0/0000", i, busy, score_update, dig);
      end
      @(negedge clk);
    end
    n_vec++;
    if (busy !== 1'b0 || score_update !== 1'b1 || dig !== 16'h0001) begin
      n_fail++;
      $display("FAIL single_commit: busy=%b upd=%b digits=%h, want 0/1/0001", busy, score_update, dig);
    end
    @(negedge clk);
    n_vec++;
    if (score_update !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse: upd=%b, want 0", score_update);
    end
  endtask

  task automatic test_carry();
    do_clear();
    n_vec++;
    if (dig !== 16'h0000) begin
      n_fail++;
      $display("FAIL carry_clear: digits=%h, want 0000", dig);
    end
    for (int i = 0; i < 12; i++) do_event(3'd4);
    do_event(3'd1);
    do_event(3'd1);
    n_vec++;
    if (dig !== 16'h0098) begin
      n_fail++;
      $display("FAIL carry_preload: digits=%h, want 0098", dig);
    end
    do_event(3'd4);
    n_vec++;
    if (dig !== 16'h0106 || score_update !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_ripple: digits=%h upd=%b, want 0106/1", dig, score_update);
    end
    do_event(3'd2);
    do_event(3'd3);
    n_vec++;
    if (dig !== 16'h0114) begin
      n_fail++;
      $display("FAIL carry_pts23: digits=%h, want 0114", dig);
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    logic [2:0] bad [2];
    bad[0] = 3'd0; bad[1] = 3'd7;
    for (int k = 0; k < 2; k++) begin
      lines_valid = 1'b1; lines_cleared = bad[k];
      @(negedge clk);
      lines_valid = 1'b0; lines_cleared = 3'd0;
      for (int i = 0; i < 7; i++) begin
        n_vec++;
        if (busy !== 1'b0 || score_update !== 1'b0 || dig !== 16'h0114) begin
          n_fail++;
          $display("FAIL ignore_lines%0d_c%0d: busy=%b upd=%b digits=%h, want 0/0/0114", bad[k], i, busy, score_update, dig);
        end
        @(negedge clk);
      end
    end
    lines_valid = 1'b1; lines_cleared = 3'd1;
    @(negedge clk);
    lines_valid = 1'b0;
    @(negedge clk);
    lines_valid = 1'b1; lines_cleared = 3'd4;
    @(negedge clk);
    lines_valid = 1'b0; lines_cleared = 3'd0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (dig !== 16'h0115 || score_update !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: digits=%h upd=%b, want 0115/1", dig, score_update);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (busy !== 1'b0 || score_update !== 1'b0 || dig !== 16'h0115) begin
        n_fail++;
        $display("FAIL b2b_dropped_c%0d: busy=%b upd=%b digits=%h, want 0/0/0115", i, busy, score_update, dig);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clear_and_reset_abort();
    lines_valid = 1'b1; lines_cleared = 3'd4;
    @(negedge clk);
    lines_valid = 1'b0; lines_cleared = 3'd0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (busy !== 1'b0 || score_update !== 1'b0 || dig !== 16'h0000) begin
        n_fail++;
        $display("FAIL clear_abort_c%0d: busy=%b upd=%b digits=%h, want 0/0/0000", i, busy, score_update, dig);
      end
      @(negedge clk);
    end
    clear = 1'b1; lines_valid = 1'b1; lines_cleared = 3'd4;
    @(negedge clk);
    clear = 1'b0; lines_valid = 1'b0; lines_cleared = 3'd0;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (busy !== 1'b0 || score_update !== 1'b0 || dig !== 16'h0000) begin
        n_fail++;
        $display("FAIL clear_wins_c%0d: busy=%b upd=%b digits=%h, want 0/0/0000", i, busy, score_update, dig);
      end
      @(negedge clk);
    end
    do_event(3'd4);
    n_vec++;
    if (dig !== 16'h0008) begin
      n_fail++;
      $display("FAIL reset_pre: digits=%h, want 0008", dig);
    end
    lines_valid = 1'b1; lines_cleared = 3'd1;
    @(negedge clk);
    lines_valid = 1'b0; lines_cleared = 3'd0;
    @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || score_update !== 1'b0 || dig !== 16'h0000 || saturated !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b upd=%b digits=%h sat=%b, want 0/0/0000/0", busy, score_update, dig, saturated);
    end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 1249; i++) do_event(3'd4);
    do_event(3'd2);
    n_vec++;
    if (dig !== 16'h9995 || saturated !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_preload: digits=%h sat=%b, want 9995/0", dig, saturated);
    end
    do_event(3'd4);
    n_vec++;
    if (dig !== 16'h9999 || saturated !== 1'b1 || score_update !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_clamp: digits=%h sat=%b upd=%b, want 9999/1/1", dig, saturated, score_update);
    end
    do_event(3'd1);
    n_vec++;
    if (dig !== 16'h9999 || saturated !== 1'b1 || score_update !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_sticky: digits=%h sat=%b upd=%b, want 9999/1/1", dig, saturated, score_update);
    end
    do_clear();
    n_vec++;
    if (dig !== 16'h0000 || saturated !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_clear: digits=%h sat=%b, want 0000/0", dig, saturated);
    end
  endtask

`ifdef SCORE_KEEPER_LEVEL_EN
  task automatic test_level();
    logic [3:0] exp_lvl [10];
    exp_lvl = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4};
    do_clear();
    for (int i = 0; i < 10; i++) begin
      do_event(3'd4);
      n_vec++;
      if (level !== exp_lvl[i] || velocity !== exp_lvl[i][3:2]) begin
        n_fail++;
        $display("FAIL level_ev%0d: level=%0d vel=%0d, want %0d/%0d", i + 1, level, velocity, exp_lvl[i], exp_lvl[i][3:2]);
      end
    end
    n_vec++;
    if (velocity !== 2'd1) begin
      n_fail++;
      $display("FAIL level_vel4: vel=%0d, want 1", velocity);
    end
    do_clear();
    n_vec++;
    if (level !== 4'd0) begin
      n_fail++;
      $display("FAIL level_clear: level=%0d, want 0", level);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_ignore_and_back_to_back();
    test_clear_and_reset_abort();
    test_saturate();
`ifdef SCORE_KEEPER_LEVEL_EN
    test_level();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
